// File: rtl/fir_seq_cu_if.sv
// ----------------------------------------------------------------------------
// fir_seq_cu_if : control bundle between the UART RX side and the FIR sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface fir_seq_cu_if #(
  parameter int AW = 3
);
  logic          FIR_strt;
  logic          buf_we;
  logic          buf_wzero;
  logic [AW-1:0] buf_waddr;
  logic [AW-1:0] buf_raddr;
  logic [AW-1:0] coef_addr;
  logic          acc_clr;
  logic          mac_en;
  logic          out_load;
  logic          out_valid;
  logic          busy;
  logic          overrun;

  // master: the start source / observer; slave: the sequencer itself
  modport master (
    output FIR_strt,
    input  buf_we, buf_wzero, buf_waddr, buf_raddr, coef_addr,
    input  acc_clr, mac_en, out_load, out_valid, busy, overrun
  );

  modport slave (
    input  FIR_strt,
    output buf_we, buf_wzero, buf_waddr, buf_raddr, coef_addr,
    output acc_clr, mac_en, out_load, out_valid, busy, overrun
  );
endinterface

`default_nettype wire

// File: rtl/fir_seq_cu.sv
// ----------------------------------------------------------------------------
// fir_seq_cu : sequencer for the shared single-MAC FIR datapath.
// Optional busy-start queue enabled by defining FIR_START_QUEUE_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fir_seq_cu #(
  parameter int TAPS = 8,
  parameter int AW   = 3,
  parameter int PIPE = 2
) (
  input  logic               clk,
  input  logic               rst,
  fir_seq_cu_if.slave        bus
);

  localparam int            DW         = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam logic [AW-1:0] c_K_LAST   = AW'(TAPS - 1);
  localparam logic [DW-1:0] c_D_LAST   = DW'(PIPE - 1);

  typedef enum logic [2:0] {
    S_FLUSH = 3'd0,
    S_IDLE  = 3'd1,
    S_WRITE = 3'd2,
    S_MAC   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_k;
  logic [DW-1:0] r_d;
  logic [AW-1:0] r_wptr;
  logic          r_pending;

  logic          r_busy;
  logic          r_buf_we;
  logic          r_buf_wzero;
  logic [AW-1:0] r_buf_waddr;
  logic [AW-1:0] r_buf_raddr;
  logic [AW-1:0] r_coef_addr;
  logic          r_acc_clr;
  logic          r_mac_en;
  logic          r_out_load;
  logic          r_out_valid;
  logic          r_overrun;

  state_t        w_state_nxt;
  logic [AW-1:0] w_k_nxt;
  logic [DW-1:0] w_d_nxt;
  logic [AW-1:0] w_wptr_nxt;
  logic          w_take;
  logic          w_busy_strt;
  logic          w_drop;
  logic          w_pending_nxt;

  assign w_busy_strt = bus.FIR_strt && (r_state != S_IDLE);

  // Next-state / counter logic; w_take marks consumption of a queued start
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_d_nxt     = r_d;
    w_wptr_nxt  = r_wptr;
    w_take      = 1'b0;
    case (r_state)
      S_FLUSH: begin
        if (r_k == c_K_LAST) begin
          w_k_nxt = '0;
          if (r_pending) begin
            w_state_nxt = S_WRITE;
            w_take      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.FIR_strt || r_pending) begin
          w_state_nxt = S_WRITE;
          w_take      = r_pending;
        end
      end
      S_WRITE: begin
        w_state_nxt = S_MAC;
        w_k_nxt     = '0;
      end
      S_MAC: begin
        w_k_nxt = r_k + 1'b1;
        if (r_k == c_K_LAST) begin
          w_state_nxt = S_DRAIN;
          w_d_nxt     = '0;
        end
      end
      S_DRAIN: begin
        if (r_d == c_D_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_d_nxt = r_d + 1'b1;
        end
      end
      S_DONE: begin
        w_wptr_nxt = r_wptr + 1'b1;
        if (r_pending) begin
          w_state_nxt = S_WRITE;
          w_take      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_FLUSH;
        w_k_nxt     = '0;
      end
    endcase
  end

`ifdef FIR_START_QUEUE_EN
  // One start may wait; an idle start arriving while a queued one is taken re-queues itself
  assign w_drop        = w_busy_strt && r_pending;
  assign w_pending_nxt = (r_pending && !w_take)
                       || (w_busy_strt && !r_pending)
                       || ((r_state == S_IDLE) && r_pending && bus.FIR_strt);
`else
  assign w_drop        = w_busy_strt;
  assign w_pending_nxt = 1'b0;
`endif

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FLUSH;
      r_k         <= '0;
      r_d         <= '0;
      r_wptr      <= '0;
      r_pending   <= 1'b0;
      r_busy      <= 1'b1;
      r_buf_we    <= 1'b1;
      r_buf_wzero <= 1'b1;
      r_buf_waddr <= '0;
      r_buf_raddr <= '0;
      r_coef_addr <= '0;
      r_acc_clr   <= 1'b0;
      r_mac_en    <= 1'b0;
      r_out_load  <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_d         <= w_d_nxt;
      r_wptr      <= w_wptr_nxt;
      r_pending   <= w_pending_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_buf_we    <= (w_state_nxt == S_FLUSH) || (w_state_nxt == S_WRITE);
      r_buf_wzero <= (w_state_nxt == S_FLUSH);
      r_buf_waddr <= (w_state_nxt == S_FLUSH) ? w_k_nxt :
                     (w_state_nxt == S_WRITE) ? w_wptr_nxt : '0;
      r_buf_raddr <= (w_state_nxt == S_MAC) ? (w_wptr_nxt - w_k_nxt) : '0;
      r_coef_addr <= (w_state_nxt == S_MAC) ? w_k_nxt : '0;
      r_acc_clr   <= (w_state_nxt == S_WRITE);
      r_mac_en    <= (w_state_nxt == S_MAC);
      r_out_load  <= (w_state_nxt == S_DONE);
      r_out_valid <= r_out_load;
      r_overrun   <= w_drop;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.buf_we    = r_buf_we;
  assign bus.buf_wzero = r_buf_wzero;
  assign bus.buf_waddr = r_buf_waddr;
  assign bus.buf_raddr = r_buf_raddr;
  assign bus.coef_addr = r_coef_addr;
  assign bus.acc_clr   = r_acc_clr;
  assign bus.mac_en    = r_mac_en;
  assign bus.out_load  = r_out_load;
  assign bus.out_valid = r_out_valid;
  assign bus.overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_fir_seq_cu.sv
// ----------------------------------------------------------------------------
// tb_fir_seq_cu : directed bench with write/result/overrun scoreboards.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fir_seq_cu;

  localparam int TAPS = 8;
  localparam int AW   = 3;
  localparam int PIPE = 2;
  localparam int LAT  = TAPS + PIPE + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_seq_cu_if #(.AW(AW)) bus ();

  fir_seq_cu #(.TAPS(TAPS), .AW(AW), .PIPE(PIPE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int nvalid   = 0;
  int wptr_m   = 0;
  int q_valid[$];
  int q_wr[$];
  int q_ov[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every sample write, result pulse and overrun must be expected
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        nvalid++;
        chk("out_valid_expected", 32'(q_valid.size() > 0), 1);
        if (q_valid.size() > 0) chk("out_valid_cycle", cyc, q_valid.pop_front());
      end
      if (bus.buf_we && !bus.buf_wzero) begin
        chk("write_expected", 32'(q_wr.size() > 0), 1);
        if (q_wr.size() > 0) chk("write_addr", 32'(bus.buf_waddr), q_wr.pop_front());
      end
      if (bus.overrun) begin
        chk("overrun_expected", 32'(q_ov.size() > 0), 1);
        if (q_ov.size() > 0) chk("overrun_cycle", cyc, q_ov.pop_front());
      end
    end
  end

  task automatic wait_neg(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drive_at(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    bus.FIR_strt = 1'b1;
    @(posedge clk);
    #1;
    bus.FIR_strt = 1'b0;
  endtask

  task automatic iso_start(bit detail);
    int t;
    int w;
    t = cyc + 1;
    w = wptr_m;
    q_wr.push_back(w);
    q_valid.push_back(t + LAT);
    wptr_m = (wptr_m + 1) % TAPS;
    drive_at(t);
    if (detail) begin
      wait_neg(t + 1);
      chk("write_acc_clr", 32'(bus.acc_clr), 1);
      chk("write_busy", 32'(bus.busy), 1);
      for (int i = 0; i < TAPS; i++) begin
        wait_neg(t + 2 + i);
        chk("mac_en", 32'(bus.mac_en), 1);
        chk("coef_addr", 32'(bus.coef_addr), i);
        chk("buf_raddr", 32'(bus.buf_raddr), (w - i) & (TAPS - 1));
      end
      wait_neg(t + TAPS + 2);
      chk("drain_mac_en", 32'(bus.mac_en), 0);
      chk("drain_raddr", 32'(bus.buf_raddr), 0);
      wait_neg(t + LAT - 1);
      chk("done_out_load", 32'(bus.out_load), 1);
    end
    wait_neg(t + LAT + 1);
    chk("back_idle", 32'(bus.busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int base;
    int t;
    int exp_valid;
    bus.FIR_strt = 1'b0;
    rst          = 1'b1;
    exp_valid    = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 1);
    chk("rst_flush_we", 32'({bus.buf_we, bus.buf_wzero}), 3);
    chk("rst_out_valid", 32'(bus.out_valid), 0);

    // Flush after reset release
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cyc;
    for (int i = 0; i < TAPS; i++) begin
      wait_neg(base + i);
      chk("flush_we_zero_busy", 32'({bus.buf_we, bus.buf_wzero, bus.busy}), 7);
      chk("flush_waddr", 32'(bus.buf_waddr), i);
    end
    wait_neg(base + TAPS);
    chk("post_flush_busy", 32'(bus.busy), 0);
    chk("post_flush_we", 32'(bus.buf_we), 0);

    // Nine isolated starts; first and last checked in detail
    iso_start(1'b1);
    for (int n = 0; n < 7; n++) iso_start(1'b0);
    iso_start(1'b1);
    exp_valid += 9;
    chk("nine_valids", nvalid, exp_valid);

`ifdef FIR_START_QUEUE_EN
    t = cyc + 1;
    q_wr.push_back(wptr_m);
    q_wr.push_back((wptr_m + 1) % TAPS);
    q_valid.push_back(t + LAT);
    q_valid.push_back(t + 2 * LAT - 1);
    q_ov.push_back(t + 8);
    wptr_m = (wptr_m + 2) % TAPS;
    drive_at(t);
    drive_at(t + 5);
    drive_at(t + 7);
    wait_neg(t + LAT);
    chk("queued_write", 32'({bus.buf_we, bus.buf_wzero}), 2);
    wait_neg(t + 2 * LAT);
    chk("queue_idle", 32'(bus.busy), 0);
    exp_valid += 2;
`else
    t = cyc + 1;
    q_wr.push_back(wptr_m);
    q_valid.push_back(t + LAT);
    q_ov.push_back(t + 6);
    wptr_m = (wptr_m + 1) % TAPS;
    drive_at(t);
    drive_at(t + 5);
    wait_neg(t + LAT + 1);
    chk("drop_idle", 32'(bus.busy), 0);
    exp_valid += 1;
`endif

    // Reset during MAC aborts the pass and restarts the flush
    t = cyc + 1;
    q_wr.push_back(wptr_m);
    drive_at(t);
    while (cyc < t + 4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 1);
    chk("abort_mac_en", 32'(bus.mac_en), 0);
    chk("abort_flush", 32'({bus.buf_we, bus.buf_wzero}), 3);
    chk("abort_waddr", 32'(bus.buf_waddr), 0);
    wptr_m = 0;
    wait_neg(t + 5 + TAPS);
    chk("abort_flush_done", 32'(bus.busy), 0);
    iso_start(1'b1);
    exp_valid += 1;

    repeat (4) @(negedge clk);
    chk("valid_count", nvalid, exp_valid);
    chk("scoreboard_empty", q_valid.size() + q_wr.size() + q_ov.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
